// File: rtl/rtp_rx_depacketizer_if.sv
// ---------------------------------------------------------------------------
// rtp_rx_depacketizer_if
//   Bundles the UDP receive byte stream and the playback sample read port
//   of the RTP/L16 receive depacketizer.
//
//   udp_rec_data_valid   source -> depacketizer  byte strobe, one run per packet
//   udp_rec_rdata        source -> depacketizer  payload byte
//   udp_rec_data_length  source -> depacketizer  UDP payload length in bytes
//   sample_rd_en         source -> depacketizer  one-cycle sample request
//   sample_out           depacketizer -> source  signed PCM sample
//   sample_out_valid     depacketizer -> source  pulse qualifying sample_out
//
//   master: the UDP/playback side driving the depacketizer.
//   slave : the depacketizer itself.
// ---------------------------------------------------------------------------
interface rtp_rx_depacketizer_if;
    logic        udp_rec_data_valid;
    logic [7:0]  udp_rec_rdata;
    logic [15:0] udp_rec_data_length;
    logic        sample_rd_en;
    logic [15:0] sample_out;
    logic        sample_out_valid;

    modport master (
        output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, sample_rd_en,
        input  sample_out, sample_out_valid
    );

    modport slave (
        input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, sample_rd_en,
        output sample_out, sample_out_valid
    );
endinterface

// File: rtl/rtp_rx_depacketizer.sv
// ---------------------------------------------------------------------------
// rtp_rx_depacketizer
//   Parses RTP/L16 packets from a UDP byte stream, checks the 12-byte RTP
//   header, unpacks big-endian 16-bit samples into a sample FIFO and hands
//   them to the playback path one per read strobe once the prefill level
//   has been reached.
//
//   clk, rst          system clock, synchronous active-high reset
//   bus (slave)       UDP byte stream in, sample read port out
//   playing           prefill reached, FIFO data is being played
//   fifo_level        samples currently stored
//   last_seq          sequence number of the last accepted packet
//   seq_gap_cnt       accepted packets with a non-consecutive sequence
//   drop_pkt_cnt      packets rejected by header check or short length
//   overflow_cnt      samples lost because the FIFO was full
//   underflow_cnt     reads served while playing with the FIFO empty
//   All counters saturate at 16'hFFFF.
// ---------------------------------------------------------------------------
module rtp_rx_depacketizer #(
    parameter logic [6:0] RTP_PT  = 7'd0,
    parameter int         FIFO_AW = 10,
    parameter int         PREFILL = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    rtp_rx_depacketizer_if.slave  bus,
    output logic                  playing,
    output logic [FIFO_AW:0]      fifo_level,
    output logic [15:0]           last_seq,
    output logic [15:0]           seq_gap_cnt,
    output logic [15:0]           drop_pkt_cnt,
    output logic [15:0]           overflow_cnt,
    output logic [15:0]           underflow_cnt
);

    localparam int               DEPTH_I   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH     = DEPTH_I[FIFO_AW:0];
    localparam logic [FIFO_AW:0] PREFILL_L = PREFILL[FIFO_AW:0];
    localparam logic [7:0]       RTP_V2    = 8'h80;  // V=2, no padding/ext/CSRC
    localparam logic [15:0]      HDR_LAST  = 16'd11;
    localparam logic [15:0]      MIN_LEN   = 16'd13;

    typedef enum logic [2:0] {
        S_WAIT_GAP,
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_DISCARD
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ------------------------------------------------------------------
    // Parser state and datapath registers
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_bcnt;      // valid bytes seen in the current run
    logic [15:0] r_len;       // length latched at header byte 0
    logic [15:0] r_seq;
    logic [7:0]  r_hi;        // pending sample MSB
    logic        r_first;
    logic [15:0] r_last_seq;
    logic [15:0] r_gap_cnt;
    logic [15:0] r_drop_cnt;

    logic w_start;            // header byte 0 accepted into the counter
    logic w_bcnt_inc;
    logic w_drop;
    logic w_seq_hi_ld;
    logic w_seq_lo_ld;
    logic w_hdr_done;
    logic w_hi_ld;
    logic w_wr_req;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_WAIT_GAP;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first so
    // that no path through the case statement can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bcnt_inc  = 1'b0;
        w_drop      = 1'b0;
        w_seq_hi_ld = 1'b0;
        w_seq_lo_ld = 1'b0;
        w_hdr_done  = 1'b0;
        w_hi_ld     = 1'b0;
        w_wr_req    = 1'b0;
        case (r_state)
            // After reset the stream may be mid-packet; wait for a gap so
            // the next byte seen really is header byte 0.
            S_WAIT_GAP: begin
                if (!bus.udp_rec_data_valid) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (bus.udp_rec_data_valid) begin
                    w_start = 1'b1;
                    if (bus.udp_rec_data_length < MIN_LEN || bus.udp_rec_rdata != RTP_V2) begin
                        w_state_nxt = S_DISCARD;
                        w_drop      = 1'b1;
                    end else begin
                        w_state_nxt = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (!bus.udp_rec_data_valid) begin
                    // Run ended before the header was complete.
                    w_state_nxt = S_IDLE;
                    w_drop      = 1'b1;
                end else begin
                    w_bcnt_inc = 1'b1;
                    case (r_bcnt)
                        16'd1: begin
                            // Marker bit [7] is ignored.
                            if (bus.udp_rec_rdata[6:0] != RTP_PT) begin
                                w_state_nxt = S_DISCARD;
                                w_drop      = 1'b1;
                            end
                        end
                        16'd2:    w_seq_hi_ld = 1'b1;
                        16'd3:    w_seq_lo_ld = 1'b1;
                        HDR_LAST: begin
                            w_state_nxt = S_PAYLOAD;
                            w_hdr_done  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (!bus.udp_rec_data_valid) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_bcnt_inc = 1'b1;
                    // Header is 12 bytes, so an even byte count is a sample MSB.
                    if (r_bcnt < r_len) begin
                        if (!r_bcnt[0]) w_hi_ld  = 1'b1;
                        else            w_wr_req = 1'b1;
                    end
                end
            end
            S_DISCARD: begin
                if (!bus.udp_rec_data_valid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_WAIT_GAP;
        endcase
    end

    // NOTE: sequential state is assigned with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt     <= '0;
            r_len      <= '0;
            r_seq      <= '0;
            r_hi       <= '0;
            r_first    <= 1'b1;
            r_last_seq <= '0;
            r_gap_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_start) begin
                r_bcnt <= 16'd1;
                r_len  <= bus.udp_rec_data_length;
            end else if (w_bcnt_inc && r_bcnt != 16'hFFFF) begin
                r_bcnt <= r_bcnt + 16'd1;
            end
            if (w_seq_hi_ld) r_seq[15:8] <= bus.udp_rec_rdata;
            if (w_seq_lo_ld) r_seq[7:0]  <= bus.udp_rec_rdata;
            if (w_hi_ld)     r_hi        <= bus.udp_rec_rdata;
            if (w_drop)      r_drop_cnt  <= sat_inc(r_drop_cnt);
            if (w_hdr_done) begin
                if (!r_first && r_seq != r_last_seq + 16'd1)
                    r_gap_cnt <= sat_inc(r_gap_cnt);
                r_last_seq <= r_seq;
                r_first    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO and playback read port
    // ------------------------------------------------------------------
    logic [15:0]        r_mem [DEPTH_I];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_playing;
    logic [15:0]        r_sample_out;
    logic               r_sample_valid;
    logic [15:0]        r_ovf_cnt;
    logic [15:0]        r_unf_cnt;

    logic [15:0] w_wr_data;
    logic        w_full;
    logic        w_empty;
    logic        w_do_wr;
    logic        w_ovf;
    logic        w_pop;
    logic        w_unf;

    // Full/empty come from the pre-cycle level, so a read of an empty FIFO
    // still underflows even if a write lands in the same cycle.
    assign w_wr_data = {r_hi, bus.udp_rec_rdata};
    assign w_full    = (r_level == DEPTH);
    assign w_empty   = (r_level == '0);
    assign w_do_wr   = w_wr_req && !w_full;
    assign w_ovf     = w_wr_req && w_full;
    assign w_pop     = bus.sample_rd_en && r_playing && !w_empty;
    assign w_unf     = bus.sample_rd_en && r_playing && w_empty;

    // NOTE: the sample array has no reset; emptiness is defined by the
    // pointers and level, which are reset, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (w_do_wr && !rst) r_mem[r_wr_ptr] <= w_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_playing      <= 1'b0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_ovf_cnt      <= '0;
            r_unf_cnt      <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{FIFO_AW{1'b0}}, w_do_wr} - {{FIFO_AW{1'b0}}, w_pop};

            if (w_ovf) r_ovf_cnt <= sat_inc(r_ovf_cnt);
            if (w_unf) r_unf_cnt <= sat_inc(r_unf_cnt);

            // Underflow drops back to buffering until prefill is reached again.
            if (w_unf)                                 r_playing <= 1'b0;
            else if (!r_playing && r_level >= PREFILL_L) r_playing <= 1'b1;

            // Every read strobe is answered; silence unless a sample is popped.
            r_sample_valid <= bus.sample_rd_en;
            if (bus.sample_rd_en) r_sample_out <= w_pop ? r_mem[r_rd_ptr] : 16'h0000;
        end
    end

    assign bus.sample_out       = r_sample_out;
    assign bus.sample_out_valid = r_sample_valid;
    assign playing              = r_playing;
    assign fifo_level           = r_level;
    assign last_seq             = r_last_seq;
    assign seq_gap_cnt          = r_gap_cnt;
    assign drop_pkt_cnt         = r_drop_cnt;
    assign overflow_cnt         = r_ovf_cnt;
    assign underflow_cnt        = r_unf_cnt;

endmodule

// File: tb/tb_rtp_rx_depacketizer.sv
// ---------------------------------------------------------------------------
// tb_rtp_rx_depacketizer
//   Self-checking bench for rtp_rx_depacketizer. A packet-level reference
//   model (sample queue plus counters) predicts every output; a table of
//   hand-computed packet vectors covers header/length corner cases.
// ---------------------------------------------------------------------------
module tb_rtp_rx_depacketizer;

    localparam int FIFO_AW = 10;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int PREFILL = 480;

    logic clk = 1'b0;
    logic rst;

    rtp_rx_depacketizer_if bus_if ();

    logic               playing;
    logic [FIFO_AW:0]   fifo_level;
    logic [15:0]        last_seq;
    logic [15:0]        seq_gap_cnt;
    logic [15:0]        drop_pkt_cnt;
    logic [15:0]        overflow_cnt;
    logic [15:0]        underflow_cnt;

    rtp_rx_depacketizer #(
        .RTP_PT (7'd0),
        .FIFO_AW(FIFO_AW),
        .PREFILL(PREFILL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .playing      (playing),
        .fifo_level   (fifo_level),
        .last_seq     (last_seq),
        .seq_gap_cnt  (seq_gap_cnt),
        .drop_pkt_cnt (drop_pkt_cnt),
        .overflow_cnt (overflow_cnt),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: packet-level rules, samples in a queue
    // ------------------------------------------------------------------
    logic [15:0] m_q[$];
    bit          m_playing;
    bit          m_first;
    logic [15:0] m_last;
    int          m_gap, m_drop, m_ovf, m_unf;

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_playing = 1'b0;
        m_first   = 1'b1;
        m_last    = 16'h0000;
        m_gap = 0; m_drop = 0; m_ovf = 0; m_unf = 0;
    endtask

    logic [7:0]  pkt[$];
    logic [15:0] sample_ctr;

    task automatic model_pkt(input int len);
        int n;
        int lim;
        logic [15:0] seq;
        n = pkt.size();
        if (len < 13 || n < 12 || pkt[0] != 8'h80 || pkt[1][6:0] != 7'd0) begin
            m_drop = sat(m_drop);
        end else begin
            seq = {pkt[2], pkt[3]};
            if (!m_first && seq != m_last + 16'd1) m_gap = sat(m_gap);
            m_last  = seq;
            m_first = 1'b0;
            lim = (n < len) ? n : len;
            for (int k = 12; k + 1 < lim; k += 2) begin
                if (m_q.size() < DEPTH) m_q.push_back({pkt[k], pkt[k+1]});
                else                    m_ovf = sat(m_ovf);
            end
        end
        if (!m_playing && m_q.size() >= PREFILL) m_playing = 1'b1;
    endtask

    task automatic model_read(output logic [15:0] e);
        e = 16'h0000;
        if (m_playing) begin
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
            end else begin
                m_unf     = sat(m_unf);
                m_playing = 1'b0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic build_pkt(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [15:0] seq, input int nbytes);
        pkt.delete();
        for (int i = 0; i < nbytes; i++) begin
            if      (i == 0) pkt.push_back(b0);
            else if (i == 1) pkt.push_back(b1);
            else if (i == 2) pkt.push_back(seq[15:8]);
            else if (i == 3) pkt.push_back(seq[7:0]);
            else if (i < 12) pkt.push_back(8'($urandom));
            else if (((i - 12) % 2) == 0) pkt.push_back(sample_ctr[15:8]);
            else begin
                pkt.push_back(sample_ctr[7:0]);
                sample_ctr = sample_ctr + 16'd1;
            end
        end
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk);
            bus_if.udp_rec_data_valid  = 1'b1;
            bus_if.udp_rec_rdata       = pkt[i];
            bus_if.udp_rec_data_length = 16'(len);
        end
        @(negedge clk);
        bus_if.udp_rec_data_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic xfer(input int len);
        send_pkt(len);
        model_pkt(len);
    endtask

    task automatic do_read(input string name);
        logic [15:0] e;
        model_read(e);
        @(negedge clk);
        bus_if.sample_rd_en = 1'b1;
        @(negedge clk);
        bus_if.sample_rd_en = 1'b0;
        check({name, ".valid"}, 32'(bus_if.sample_out_valid), 32'd1);
        check({name, ".data"},  32'(bus_if.sample_out),       32'(e));
    endtask

    task automatic check_status(input string tag);
        check({tag, ".level"},     32'(fifo_level),    32'(m_q.size()));
        check({tag, ".playing"},   32'(playing),       32'(m_playing));
        check({tag, ".last_seq"},  32'(last_seq),      32'(m_last));
        check({tag, ".gap_cnt"},   32'(seq_gap_cnt),   32'(m_gap));
        check({tag, ".drop_cnt"},  32'(drop_pkt_cnt),  32'(m_drop));
        check({tag, ".ovf_cnt"},   32'(overflow_cnt),  32'(m_ovf));
        check({tag, ".unf_cnt"},   32'(underflow_cnt), 32'(m_unf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.udp_rec_data_valid  = 1'b0;
        bus_if.udp_rec_rdata       = 8'h00;
        bus_if.udp_rec_data_length = 16'h0000;
        bus_if.sample_rd_en        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Packet vector table: header fields, lengths and expected increments
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] seq;
        int          len;
        int          nbytes;
        int          d_drop;
        int          d_gap;
        int          d_lvl;
    } vec_t;

    vec_t tbl[12];

    int          e_drop, e_gap, e_lvl;
    int          kind, n, len;
    logic [7:0]  rb0, rb1;
    logic [15:0] rseq;

    initial begin
        //             b0     b1     seq       len  n    drop gap lvl
        tbl[0]  = '{8'h90, 8'h00, 16'h0006,  20,  20,  1,  0,  0};  // bad version byte
        tbl[1]  = '{8'h80, 8'h01, 16'h0006,  20,  20,  1,  0,  0};  // wrong PT
        tbl[2]  = '{8'h80, 8'h80, 16'h0006,  20,  20,  0,  0,  4};  // marker set, PT ok
        tbl[3]  = '{8'h80, 8'h00, 16'h0008,  16,  16,  0,  1,  2};  // seq 6 -> 8 gap
        tbl[4]  = '{8'h80, 8'h00, 16'hFFFF,  14,  14,  0,  1,  1};  // 8 -> FFFF gap
        tbl[5]  = '{8'h80, 8'h00, 16'h0000,  15,  15,  0,  0,  1};  // wrap, odd byte dropped
        tbl[6]  = '{8'h80, 8'h00, 16'h0001,  12,  12,  1,  0,  0};  // length < 13
        tbl[7]  = '{8'h80, 8'h00, 16'h0001,  13,  13,  0,  0,  0};  // single odd byte
        tbl[8]  = '{8'h80, 8'h00, 16'h0002,  40,   8,  1,  0,  0};  // run ends in header
        tbl[9]  = '{8'h80, 8'h00, 16'h0002,  16,  24,  0,  0,  2};  // bytes past length ignored
        tbl[10] = '{8'h80, 8'h00, 16'h0003, 100,  18,  0,  0,  3};  // short run vs length
        tbl[11] = '{8'h80, 8'h7F, 16'h0004,  20,  20,  1,  0,  0};  // PT 127

        sample_ctr = 16'h0001;
        do_reset();

        // Reset state
        check("rst.sample_out",   32'(bus_if.sample_out),       32'd0);
        check("rst.sample_valid", 32'(bus_if.sample_out_valid), 32'd0);
        check("rst.level",        32'(fifo_level),              32'd0);
        check("rst.playing",      32'(playing),                 32'd0);
        check("rst.last_seq",     32'(last_seq),                32'd0);
        check("rst.gap",          32'(seq_gap_cnt),             32'd0);
        check("rst.drop",         32'(drop_pkt_cnt),            32'd0);
        check("rst.ovf",          32'(overflow_cnt),            32'd0);
        check("rst.unf",          32'(underflow_cnt),           32'd0);

        // One full 480-sample packet, payload 0x0001..0x01E0
        build_pkt(8'h80, 8'h00, 16'h0005, 972);
        xfer(972);
        check("p1.level",    32'(fifo_level), 32'd480);
        check("p1.playing",  32'(playing),    32'd1);
        check("p1.last_seq", 32'(last_seq),   32'd5);
        for (int i = 0; i < 480; i++) begin
            check("p1.expect", 32'(m_q[0]), 32'(i + 1));
            do_read("p1.rd");
        end
        // Extra read on empty FIFO while playing: silence, underflow, rebuffer
        do_read("p1.unf");
        check("p1.unf_cnt", 32'(underflow_cnt), 32'd1);
        check("p1.playing", 32'(playing),       32'd0);
        check_status("p1");

        // Table-driven header / length corner cases
        e_drop = 0; e_gap = 0; e_lvl = 0;
        for (int v = 0; v < 12; v++) begin
            build_pkt(tbl[v].b0, tbl[v].b1, tbl[v].seq, tbl[v].nbytes);
            xfer(tbl[v].len);
            e_drop += tbl[v].d_drop;
            e_gap  += tbl[v].d_gap;
            e_lvl  += tbl[v].d_lvl;
            check($sformatf("tbl%0d.drop", v),  32'(drop_pkt_cnt), 32'(e_drop));
            check($sformatf("tbl%0d.gap", v),   32'(seq_gap_cnt),  32'(e_gap));
            check($sformatf("tbl%0d.level", v), 32'(fifo_level),   32'(e_lvl));
            check_status($sformatf("tbl%0d", v));
        end

        // Read during prefill: silence, FIFO untouched
        do_read("prefill.rd");
        check("prefill.level", 32'(fifo_level), 32'd13);
        check_status("prefill");

        // Fill to 1024 (13 + 480 + 480 + 51) then 10 more samples overflow
        build_pkt(8'h80, 8'h00, 16'h0005, 972); xfer(972);
        build_pkt(8'h80, 8'h00, 16'h0006, 972); xfer(972);
        build_pkt(8'h80, 8'h00, 16'h0007, 134); xfer(134);
        check("ovf.cnt",     32'(overflow_cnt), 32'd10);
        check("ovf.level",   32'(fifo_level),   32'd1024);
        check("ovf.playing", 32'(playing),      32'd1);
        check_status("ovf");

        // Drain all, then one read too many
        for (int i = 0; i < DEPTH; i++) do_read("drain.rd");
        do_read("drain.unf");
        check("drain.unf_cnt", 32'(underflow_cnt), 32'd2);
        check("drain.playing", 32'(playing),       32'd0);
        check("drain.level",   32'(fifo_level),    32'd0);
        check_status("drain");

        // Reset at payload byte 100, released while the run is still going
        build_pkt(8'h80, 8'h00, 16'h0100, 300);
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk);
            bus_if.udp_rec_data_valid  = 1'b1;
            bus_if.udp_rec_rdata       = pkt[i];
            bus_if.udp_rec_data_length = 16'd300;
            if (i == 112) rst = 1'b1;
            if (i == 114) rst = 1'b0;
        end
        @(negedge clk);
        bus_if.udp_rec_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check_status("midrst");
        build_pkt(8'h80, 8'h00, 16'h1234, 15);
        xfer(15);
        check("midrst.level",    32'(fifo_level), 32'd1);
        check("midrst.last_seq", 32'(last_seq),   32'h1234);
        check("midrst.gap",      32'(seq_gap_cnt), 32'd0);
        check_status("midrst.next");

        // Randomized packets and read bursts against the model
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 9);
            rb0  = 8'h80;
            rb1  = {1'($urandom_range(0, 1)), 7'd0};
            rseq = ($urandom_range(0, 3) == 0) ? 16'($urandom) : m_last + 16'd1;
            n    = $urandom_range(12, 260);
            len  = n;
            case (kind)
                0: rb0     = 8'h80 ^ 8'($urandom_range(1, 255));
                1: rb1[6:0] = 7'($urandom_range(1, 127));
                2: len     = $urandom_range(0, 12);
                3: len     = $urandom_range(13, 300);
                4: n       = $urandom_range(1, 11);
                default: ;
            endcase
            build_pkt(rb0, rb1, rseq, n);
            xfer(len);
            repeat ($urandom_range(0, 80)) do_read("rnd.rd");
            check_status($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
